// File: rtl/otn_frame_tx.sv
// Transmit framer: buffers one frame, sends it as back-to-back 8N1 characters and,
// with ARQ enabled, retransmits from the buffer on NAK or ACK timeout.
module otn_frame_tx #(
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  ACK_CODE    = 8'h06,
    parameter logic [7:0]  NAK_CODE    = 8'h15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_arq_en,
    input  logic [7:0] i_frame_data,
    input  logic       i_frame_data_valid,
    output logic       o_frame_data_ready,
    output logic       o_otn_tx_data,
    input  logic       i_otn_rx_ack,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_frame_drop,
    output logic [7:0] o_retry_cnt
);
    localparam int unsigned IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [1:0] {ST_LOAD, ST_SEND, ST_WAIT_ACK} state_t;

    state_t           state_q;
    logic [7:0]       mem_q [FRAME_BYTES];
    logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
    logic             ready_q, busy_q, tx_q, done_q, drop_q, arq_q, run_q;
    logic [7:0]       retry_q;
    logic [3:0]       tick_cnt_q, bit_idx_q;
    logic [TO_W-1:0]  to_q;
    logic [1:0]       sync_q;
    logic             rx_prev_q, rx_busy_q;
    logic [3:0]       rx_cnt_q, rx_bit_q;
    logic [7:0]       rx_sh_q;

    logic       wr_fire_c, bit_end_c, rx_stop_c, is_ack_c, is_nak_c, to_exp_c;
    logic [7:0] cur_byte_c;

    assign wr_fire_c  = ready_q & i_frame_data_valid & (state_q == ST_LOAD);
    assign bit_end_c  = i_sclk_en_16_x_baud & (tick_cnt_q == 4'd15);
    assign cur_byte_c = mem_q[rd_idx_q];
    assign rx_stop_c  = (state_q == ST_WAIT_ACK) & rx_busy_q & i_sclk_en_16_x_baud
                        & (rx_bit_q == 4'd9) & (rx_cnt_q == 4'd15);
    assign is_ack_c   = rx_stop_c & sync_q[1] & (rx_sh_q == ACK_CODE);
    assign is_nak_c   = rx_stop_c & sync_q[1] & (rx_sh_q == NAK_CODE);
    assign to_exp_c   = (state_q == ST_WAIT_ACK) & bit_end_c & (to_q == TO_LAST);

    // Frame buffer is only written in LOAD, so retransmissions replay it unchanged
    always_ff @(posedge i_clk) begin
        if (wr_fire_c) begin
            mem_q[wr_idx_q] <= i_frame_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_LOAD;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            arq_q      <= 1'b0;
            run_q      <= 1'b0;
            retry_q    <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            to_q       <= '0;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            if (i_sclk_en_16_x_baud) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
            end
            case (state_q)
                ST_LOAD: begin
                    ready_q <= 1'b1;
                    if (wr_fire_c) begin
                        if (wr_idx_q == LAST_IDX) begin
                            wr_idx_q <= '0;
                            rd_idx_q <= '0;
                            ready_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            arq_q    <= i_arq_en;
                            retry_q  <= '0;
                            run_q    <= 1'b0;
                            state_q  <= ST_SEND;
                        end else begin
                            wr_idx_q <= wr_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (!run_q) begin
                        // First start bit is launched on the first tick after entry
                        if (i_sclk_en_16_x_baud) begin
                            run_q      <= 1'b1;
                            tx_q       <= 1'b0;
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                        end
                    end else if (bit_end_c) begin
                        if (bit_idx_q == 4'd9) begin
                            if (rd_idx_q == LAST_IDX) begin
                                run_q <= 1'b0;
                                if (arq_q) begin
                                    to_q    <= '0;
                                    state_q <= ST_WAIT_ACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_LOAD;
                                end
                            end else begin
                                rd_idx_q  <= rd_idx_q + IDX_W'(1);
                                bit_idx_q <= '0;
                                tx_q      <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : cur_byte_c[bit_idx_q[2:0]];
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (bit_end_c && !to_exp_c) begin
                        to_q <= to_q + TO_W'(1);
                    end
                    // A decoded character wins over a timeout expiring in the same cycle
                    if (is_ack_c) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else if (is_nak_c || to_exp_c) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q    <= retry_q + 8'd1;
                            rd_idx_q   <= '0;
                            run_q      <= 1'b1;
                            tx_q       <= 1'b0;
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            state_q    <= ST_SEND;
                        end else begin
                            busy_q  <= 1'b0;
                            drop_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // ACK/NAK deserializer: mid-bit sampling at 16x, active only while waiting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            rx_busy_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], i_otn_rx_ack};
            rx_prev_q <= sync_q[1];
            if (state_q != ST_WAIT_ACK) begin
                rx_busy_q <= 1'b0;
                rx_cnt_q  <= '0;
                rx_bit_q  <= '0;
                rx_sh_q   <= '0;
            end else if (!rx_busy_q) begin
                if (rx_prev_q && !sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                end
            end else if (i_sclk_en_16_x_baud) begin
                rx_cnt_q <= rx_cnt_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_cnt_q == 4'd7) begin
                        if (!sync_q[1]) begin
                            rx_bit_q <= 4'd1;
                            rx_cnt_q <= '0;
                        end else begin
                            rx_busy_q <= 1'b0;
                        end
                    end
                end else if (rx_cnt_q == 4'd15) begin
                    if (rx_bit_q == 4'd9) begin
                        rx_busy_q <= 1'b0;
                    end else begin
                        rx_sh_q  <= {sync_q[1], rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 4'd1;
                    end
                end
            end
        end
    end

    assign o_frame_data_ready = ready_q;
    assign o_otn_tx_data      = tx_q;
    assign o_busy             = busy_q;
    assign o_frame_done       = done_q;
    assign o_frame_drop       = drop_q;
    assign o_retry_cnt        = retry_q;

endmodule

// File: tb/tb_otn_frame_tx.sv
// Directed/randomized bench for otn_frame_tx: decodes the serial line at tick
// resolution and compares characters and timing against a frame-level model.
module tb_otn_frame_tx;
    localparam int FB      = 16;
    localparam int TO_TCK  = 64 * 16;
    localparam int CHR_TCK = 160;

    logic       clk = 1'b0;
    logic       rst, tick, arq_en, valid, rx_ack;
    logic [7:0] data;
    logic       ready, tx, busy, done, drop;
    logic [7:0] retry;

    int checks = 0;
    int errors = 0;

    int         ticks_done = 0;
    bit         prev_tx = 1'b1;
    bit         dec_busy = 1'b0;
    int         dec_t0, dec_next, dec_k;
    logic [7:0] dec_sh;
    logic [7:0] rx_chars[$];
    int         rx_t0[$];
    int         rx_start_t[$];
    int         rx_starts = 0;
    int         frame_err = 0;
    bit         inj_q[$];
    int         inj_next = 0;
    int         done_cnt = 0, drop_cnt = 0, done_tick = 0, drop_tick = 0;
    logic [7:0] retry_at_evt = '0;
    bit         evt_prev = 1'b0;
    logic [7:0] exp_frame[FB];
    int         load_end_tick = 0;

    otn_frame_tx dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_sclk_en_16_x_baud (tick),
        .i_arq_en            (arq_en),
        .i_frame_data        (data),
        .i_frame_data_valid  (valid),
        .o_frame_data_ready  (ready),
        .o_otn_tx_data       (tx),
        .i_otn_rx_ack        (rx_ack),
        .o_busy              (busy),
        .o_frame_done        (done),
        .o_frame_drop        (drop),
        .o_retry_cnt         (retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive the next tick
    task automatic step();
        @(negedge clk);
        if (tick) ticks_done++;
        if (evt_prev) chk("ready_after_evt", 32'(ready), 32'd1);
        evt_prev = done || drop;
        if (done || drop) begin
            chk("done_drop_exclusive", 32'(done & drop), 32'd0);
            if (done) begin done_cnt++; done_tick = ticks_done; end
            if (drop) begin drop_cnt++; drop_tick = ticks_done; end
            retry_at_evt = retry;
        end
        if (!dec_busy) begin
            if (prev_tx && tx === 1'b0) begin
                dec_busy = 1'b1;
                dec_t0   = ticks_done;
                dec_next = ticks_done + 8;
                dec_k    = 0;
                rx_starts++;
                rx_start_t.push_back(ticks_done);
            end
        end else if (ticks_done == dec_next) begin
            if (dec_k == 0) begin
                if (tx !== 1'b0) frame_err++;
            end else if (dec_k <= 8) begin
                dec_sh = {tx, dec_sh[7:1]};
            end else begin
                if (tx !== 1'b1) frame_err++;
                rx_chars.push_back(dec_sh);
                rx_t0.push_back(dec_t0);
                dec_busy = 1'b0;
            end
            dec_k++;
            dec_next += 16;
        end
        prev_tx = (tx === 1'b1);
        if (inj_q.size() > 0 && ticks_done >= inj_next) begin
            rx_ack   = inj_q.pop_front();
            inj_next = ticks_done + 16;
        end
        tick = ($urandom_range(0, 3) != 0);
    endtask

    task automatic inject(input logic [7:0] c, input bit stop_bit, input int at_tick);
        if (inj_q.size() == 0) inj_next = at_tick;
        inj_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) inj_q.push_back(c[i]);
        inj_q.push_back(stop_bit);
        inj_q.push_back(1'b1);
    endtask

    task automatic clear_mon();
        rx_chars.delete();
        rx_t0.delete();
        rx_start_t.delete();
        rx_starts = 0;
        frame_err = 0;
    endtask

    task automatic load_frame(input bit arq, input bit toggle);
        int idx = 0;
        int guard = 0;
        logic rdy;
        arq_en = arq;
        while (idx < FB && guard < 2000) begin
            valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            data  = exp_frame[idx];
            rdy   = ready;
            step();
            if (valid && rdy) idx++;
            guard++;
        end
        valid = 1'b0;
        load_end_tick = ticks_done;
        chk("load_bytes_taken", 32'(idx), 32'(FB));
        chk("ready_drop_after_last", 32'(ready), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd1);
    endtask

    task automatic wait_chars(input int n, input int budget, input string tag);
        int c = 0;
        while (rx_chars.size() < n && c < budget) begin step(); c++; end
        chk(tag, 32'(rx_chars.size()), 32'(n));
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int c = 0;
        while (rx_starts < n && c < budget) begin step(); c++; end
        chk(tag, 32'(rx_starts), 32'(n));
    endtask

    task automatic wait_evt(input int target, input int budget, input string tag);
        int c = 0;
        while (done_cnt + drop_cnt < target && c < budget) begin step(); c++; end
        chk(tag, 32'(done_cnt + drop_cnt), 32'(target));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int frame_mism(input int base);
        int m = 0;
        for (int i = 0; i < FB; i++) begin
            if (base + i >= rx_chars.size()) m++;
            else if (rx_chars[base + i] !== exp_frame[i]) m++;
        end
        return m;
    endfunction

    function automatic int gap_mism(input int base);
        int m = 0;
        for (int i = 1; i < FB; i++) begin
            if (base + i >= rx_t0.size()) m++;
            else if (rx_t0[base + i] - rx_t0[base + i - 1] != CHR_TCK) m++;
        end
        return m;
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < FB; i++) exp_frame[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int base_done, base_drop, end_stop;
        rst = 1'b1; tick = 1'b0; arq_en = 1'b0; valid = 1'b0; data = '0; rx_ack = 1'b1;
        idle(4);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_retry", 32'(retry), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_release", 32'(ready), 32'd1);

        // ARQ off: incrementing frame, single delivery
        for (int i = 0; i < FB; i++) exp_frame[i] = 8'(i);
        clear_mon();
        base_done = done_cnt;
        load_frame(1'b0, 1'b0);
        wait_evt(done_cnt + drop_cnt + 1, 6000, "noarq_done_wait");
        chk("noarq_chars", 32'(frame_mism(0)), 32'd0);
        chk("noarq_first_start", 32'(rx_t0[0]), 32'(load_end_tick + 1));
        chk("noarq_back_to_back", 32'(gap_mism(0)), 32'd0);
        chk("noarq_frame_len", 32'(done_tick - rx_t0[0]), 32'(FB * CHR_TCK));
        chk("noarq_framing", 32'(frame_err), 32'd0);
        idle(40);
        chk("noarq_done_once", 32'(done_cnt - base_done), 32'd1);

        // ACK accepted first time
        for (int i = 0; i < FB; i++) exp_frame[i] = 8'hA5;
        clear_mon();
        base_done = done_cnt; base_drop = drop_cnt;
        load_frame(1'b1, 1'b0);
        wait_chars(FB, 6000, "ack_frame_wait");
        end_stop = rx_t0[FB-1] + CHR_TCK;
        inject(8'h06, 1'b1, end_stop + 5 * 16);
        wait_evt(done_cnt + drop_cnt + 1, 3000, "ack_done_wait");
        chk("ack_retry_at_done", 32'(retry_at_evt), 32'd0);
        idle(400);
        chk("ack_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("ack_no_drop", 32'(drop_cnt - base_drop), 32'd0);
        chk("ack_no_retx", 32'(rx_starts), 32'(FB));
        chk("ack_chars", 32'(frame_mism(0)), 32'd0);

        // NAK then ACK: one identical retransmission
        rand_frame();
        clear_mon();
        base_done = done_cnt; base_drop = drop_cnt;
        load_frame(1'b1, 1'b0);
        wait_chars(FB, 6000, "nak_frame_wait");
        inject(8'h15, 1'b1, rx_t0[FB-1] + CHR_TCK + 5 * 16);
        wait_chars(2 * FB, 7000, "nak_retx_wait");
        inject(8'h06, 1'b1, rx_t0[2*FB-1] + CHR_TCK + 5 * 16);
        wait_evt(done_cnt + drop_cnt + 1, 3000, "nak_done_wait");
        chk("nak_retry_at_done", 32'(retry_at_evt), 32'd1);
        chk("nak_first_copy", 32'(frame_mism(0)), 32'd0);
        chk("nak_second_copy", 32'(frame_mism(FB)), 32'd0);
        idle(400);
        chk("nak_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("nak_no_drop", 32'(drop_cnt - base_drop), 32'd0);
        chk("nak_two_sends", 32'(rx_starts), 32'(2 * FB));

        // Silence: four transmissions, each followed by a full timeout, then drop
        rand_frame();
        clear_mon();
        base_done = done_cnt; base_drop = drop_cnt;
        load_frame(1'b1, 1'b0);
        wait_evt(done_cnt + drop_cnt + 1, 30000, "to_drop_wait");
        chk("to_drop_once", 32'(drop_cnt - base_drop), 32'd1);
        chk("to_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("to_retry_at_drop", 32'(retry_at_evt), 32'd3);
        chk("to_char_count", 32'(rx_chars.size()), 32'(4 * FB));
        for (int k = 0; k < 4; k++) begin
            chk("to_copy", 32'(frame_mism(k * FB) + gap_mism(k * FB)), 32'd0);
        end
        for (int k = 1; k < 4; k++) begin
            chk("to_idle_gap", 32'(rx_t0[k*FB] - (rx_t0[k*FB-1] + CHR_TCK)), 32'(TO_TCK));
        end
        chk("to_drop_time", 32'(drop_tick - (rx_t0[4*FB-1] + CHR_TCK)), 32'(TO_TCK));
        chk("to_framing", 32'(frame_err), 32'd0);

        // Unknown character and bad-stop ACK are ignored; timeout still fires
        rand_frame();
        clear_mon();
        base_done = done_cnt;
        load_frame(1'b1, 1'b0);
        wait_chars(FB, 6000, "inv_frame_wait");
        end_stop = rx_t0[FB-1] + CHR_TCK;
        inject(8'h41, 1'b1, end_stop + 5 * 16);
        inject(8'h06, 1'b0, end_stop + 5 * 16);
        wait_starts(FB + 1, 4000, "inv_retx_wait");
        chk("inv_timeout_gap", 32'(rx_start_t[FB] - end_stop), 32'(TO_TCK));
        chk("inv_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("inv_retry", 32'(retry), 32'd1);

        // Reset during the start bit of retransmitted byte 7
        wait_starts(FB + 8, 4000, "rst_byte7_wait");
        chk("rst_line_low_before", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_line_async", 32'(tx), 32'd1);
        chk("rst_ready_async", 32'(ready), 32'd0);
        dec_busy = 1'b0;
        idle(2);
        chk("rst_busy_clear", 32'(busy), 32'd0);
        chk("rst_retry_clear", 32'(retry), 32'd0);
        rst = 1'b0;
        chk("rst_ready_at_release", 32'(ready), 32'd0);
        step();
        chk("rst_ready_one_cycle", 32'(ready), 32'd1);

        // New frame with gapped valid starts from byte 0
        rand_frame();
        clear_mon();
        base_done = done_cnt;
        load_frame(1'b0, 1'b1);
        wait_evt(done_cnt + drop_cnt + 1, 6000, "bp_done_wait");
        chk("bp_chars", 32'(frame_mism(0)), 32'd0);
        chk("bp_first_start", 32'(rx_t0[0]), 32'(load_end_tick + 1));
        chk("bp_back_to_back", 32'(gap_mism(0)), 32'd0);
        chk("bp_framing", 32'(frame_err), 32'd0);
        idle(20);
        chk("bp_done_once", 32'(done_cnt - base_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/otn_frame_tx.md
# otn_frame_tx

- Transmit-side serial framer that sits directly upstream of `receiver`.
- Buffers one frame of `FRAME_BYTES` bytes from the mapper.
- Serializes the frame onto `o_otn_tx_data` as back-to-back 8N1 characters, paced by the shared 16x-baud enable.
- With ARQ enabled, waits for an ACK/NAK character on `i_otn_rx_ack` and retransmits from its buffer on NAK or timeout, up to `MAX_RETRY` times.

## Interface

**Clock and reset:** one clock (`i_clk`); reset `i_rst` is asynchronous and active-high.

**Parameters**
- `FRAME_BYTES`, 16: bytes per frame, 2..256.
- `ACK_TIMEOUT`, 64: bit periods to wait for an ACK/NAK.
- `MAX_RETRY`, 3: retransmissions before the frame is dropped.
- `ACK_CODE`, 8'h06: character meaning frame accepted.
- `NAK_CODE`, 8'h15: character meaning frame rejected.

**Ports**
- `i_clk` in 1: system clock.
- `i_rst` in 1: async active-high reset.
- `i_sclk_en_16_x_baud` in 1: one-cycle tick, 16 per bit period.
- `i_arq_en` in 1: ARQ enable, sampled when a frame leaves LOAD.
- `i_frame_data` in 8: frame byte from mapper.
- `i_frame_data_valid` in 1: byte valid.
- `o_frame_data_ready` out 1: block accepts a byte.
- `o_otn_tx_data` out 1: serial line to receiver, idle high.
- `i_otn_rx_ack` in 1: serial ACK/NAK line from receiver, idle high, asynchronous to the byte stream.
- `o_busy` out 1: high in any state except LOAD.
- `o_frame_done` out 1: one-cycle pulse when a frame is released as delivered.
- `o_frame_drop` out 1: one-cycle pulse when a frame is discarded after the retry limit.
- `o_retry_cnt` out 8: retransmissions of the current frame, saturating at `MAX_RETRY`.

## Operation

**State machine:** LOAD → SEND → (WAIT_ACK) → LOAD.

**LOAD**
- `o_frame_data_ready`=1.
- Each cycle with valid&ready writes `i_frame_data` to `buf[wr_idx]` and increments `wr_idx`.
- On the write of byte `FRAME_BYTES-1`, ready drops the next cycle.
- In the same cycle: go to SEND, latch `arq_r`=`i_arq_en`, clear `o_retry_cnt`.

**SEND**
- For `rd_idx`=0..`FRAME_BYTES-1`, emit start 0, `buf[rd_idx]` LSB first, stop 1: 10 bit periods per byte.
- Bytes are back-to-back with no idle gap.
- After the last stop bit:
  - if `arq_r`=0: pulse `o_frame_done`, go to LOAD;
  - else: go to WAIT_ACK with timeout counter cleared.

**WAIT_ACK**
- Line held high.
- ACK deserializer:
  - 2-flop synchronizer on `i_otn_rx_ack`;
  - a high→low transition starts a character;
  - sample at tick 8 of the start bit; the start bit must still read 0, otherwise return to hunt;
  - then sample every 16 ticks: 8 data bits LSB first, then stop;
  - a stop bit of 0 discards the character.
- `ACK_CODE`: pulse `o_frame_done`, go to LOAD.
- `NAK_CODE`, or timeout counter reaching `ACK_TIMEOUT` bit periods:
  - if `o_retry_cnt` < `MAX_RETRY`: increment it, set `rd_idx`=0, go to SEND;
  - else: pulse `o_frame_drop`, go to LOAD.
- Any other valid character is ignored and does not reset the timeout.
- Simultaneous events: a character whose stop bit is sampled in the same cycle the timeout expires is decoded and takes priority over the timeout.
- The deserializer is idle and cleared outside WAIT_ACK.

**Retransmission**
- The buffer is never written outside LOAD, so retransmitted frames are bit-identical to the original.

## Timing

**Bit timing**
- A 4-bit tick counter advances only on `i_sclk_en_16_x_baud`.
- `o_otn_tx_data` is registered and changes in the cycle after the tick that completes a bit period (16th tick).
- The first start bit begins on the tick following SEND entry.
- A frame occupies exactly `10*FRAME_BYTES` bit periods on the line.

**Handshake**
- The transfer occurs when valid&ready are high at the clock edge.
- Valid may be held indefinitely; the block does not require valid to be continuous.

**Pulses and turnaround**
- `o_frame_done` and `o_frame_drop` are registered, exactly 1 cycle each, and never coincide.
- LOAD re-entry asserts ready in the cycle after the done/drop pulse.

**Reset values**
- Outputs: `o_otn_tx_data`=1, `o_frame_data_ready`=0 (rises the first clock after reset release), `o_busy`=0, pulses=0, `o_retry_cnt`=0.
- Internal: state=LOAD, all indices and counters 0.
- Reset mid-frame aborts immediately: the line returns high asynchronously and buffer contents are discarded (`wr_idx`=0).

**Widths**
- `wr_idx`/`rd_idx` are `clog2(FRAME_BYTES)` bits.
- The timeout counter is `clog2(ACK_TIMEOUT+1)` bits and counts bit periods, not clocks.

## Test plan

- **ARQ off:** `i_arq_en`=0, send bytes 0x00..0x0F; decode line → 16 characters 0x00..0x0F, LSB first, 160 bit periods; one `o_frame_done`; ready high the next cycle.
- **ACK:** `i_arq_en`=1, frame 0xA5 repeated; inject 0x06 on `i_otn_rx_ack` 5 bit periods after the last stop → `o_frame_done`, `o_retry_cnt`=0, no retransmission.
- **NAK then ACK:** inject 0x15 then, after the retransmit, 0x06 → frame sent twice, identical; `o_retry_cnt`=1 at done.
- **Timeout and drop:** no response, `MAX_RETRY`=3, `ACK_TIMEOUT`=64 → 4 transmissions, each followed by exactly 64 bit periods idle; then one `o_frame_drop` and no `o_frame_done`.
- **Invalid characters:** 0x41 and a 0x06 with stop bit forced 0 → both ignored; timeout still fires at 64 bit periods.
- **Reset mid-frame and backpressure:** assert `i_rst` during byte 7 of SEND → line high the same cycle, ready 0, then 1 one cycle after release; the next frame starts at `buf[0]` with new data. Valid toggling 1/0 during LOAD → all 16 bytes captured in order.
